// File: rtl/nmt_pkg.sv
// Shared types and constants for the NMT MEM stage.
package nmt_pkg;

   localparam int DATA_W_D = 32;
   localparam int ADDR_W_D = 9;

   localparam logic [DATA_W_D-1:0] CMD_ALU   = 32'd0;
   localparam logic [DATA_W_D-1:0] CMD_LOAD  = 32'd1;
   localparam logic [DATA_W_D-1:0] CMD_STORE = 32'd2;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HOLD   = 2'd1,
      SWITCH = 2'd2
   } mem_state_t;

endpackage

// File: rtl/nmt_data_ram.sv
// Local data memory: registered-read host port plus an NMT port with
// combinational read. Reads return the contents before this cycle's writes.
module nmt_data_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_host_we,
   input  logic              i_host_re,
   input  logic [ADDR_W-1:0] i_host_addr,
   input  logic [DATA_W-1:0] i_host_wdata,
   output logic [DATA_W-1:0] o_host_rdata,
   input  logic              i_nmt_we,
   input  logic [ADDR_W-1:0] i_nmt_addr,
   input  logic [DATA_W-1:0] i_nmt_wdata,
   output logic [DATA_W-1:0] o_nmt_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_host_rdata;

   // The stage never issues both writes to the same word in one cycle.
   always_ff @(posedge clk) begin
      if (i_host_we) r_mem[i_host_addr] <= i_host_wdata;
      if (i_nmt_we)  r_mem[i_nmt_addr]  <= i_nmt_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)         r_host_rdata <= '0;
      else if (i_host_re) r_host_rdata <= r_mem[i_host_addr];
   end

   assign o_host_rdata = r_host_rdata;
   assign o_nmt_rdata  = r_mem[i_nmt_addr];

endmodule

// File: rtl/nmt_mem_stage.sv
// NMT pipeline MEM stage: loads/stores on local memory, host access with
// priority, collision hold with bounded retry and context-switch request.
//
//   state  | meaning
//   RUN    | accept upstream op each cycle, execute unless it collides
//   HOLD   | replay pending op; stall upstream while the host blocks it
//   SWITCH | retries exhausted: drop pending op, request context switch
module nmt_mem_stage
   import nmt_pkg::*;
#(
   parameter int DATA_W    = DATA_W_D,
   parameter int ADDR_W    = ADDR_W_D,
   parameter int DEPTH     = 2**ADDR_W,
   parameter int MAX_RETRY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] alu_i,
   input  logic [DATA_W-1:0] instr_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic [DATA_W-1:0] cmd_type_i,
   input  logic              host_req,
   input  logic              host_rd_wr,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] alu_o,
   output logic [DATA_W-1:0] ir_o,
   output logic [DATA_W-1:0] lmd_o,
   output logic              valid_o,
   output logic              stall_o,
   output logic              context_switch_o,
   output logic              addr_err_o
);

   localparam int CNT_W = $clog2(MAX_RETRY + 1);

   mem_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_retry_cnt;
   logic [DATA_W-1:0] r_p_alu, r_p_instr, r_p_reg2;
   logic              r_p_store;
   logic [DATA_W-1:0] r_alu, r_ir, r_lmd;
   logic              r_valid, r_addr_err, r_host_ack;

   logic              w_op_valid;
   logic [DATA_W-1:0] w_op_alu, w_op_instr, w_op_reg2, w_op_cmd;
   logic              w_is_load, w_is_store, w_addr_err, w_collide, w_exec, w_nmt_we;
   logic [DATA_W-1:0] w_nmt_rdata;

   always_comb begin
      w_op_valid  = 1'b0;
      w_op_alu    = alu_i;
      w_op_instr  = instr_i;
      w_op_reg2   = reg2_i;
      w_op_cmd    = cmd_type_i;
      w_state_nxt = r_state;

      case (r_state)
         RUN:  w_op_valid = valid_i;
         HOLD: begin
            w_op_valid = 1'b1;
            w_op_alu   = r_p_alu;
            w_op_instr = r_p_instr;
            w_op_reg2  = r_p_reg2;
            w_op_cmd   = r_p_store ? CMD_STORE : CMD_LOAD;
         end
         default: w_op_valid = 1'b0;
      endcase

      w_is_load  = (w_op_cmd == CMD_LOAD);
      w_is_store = (w_op_cmd == CMD_STORE);
      w_addr_err = (w_is_load || w_is_store) && (w_op_alu[DATA_W-1:ADDR_W] != '0);
      // An out-of-range op never touches memory, so it cannot collide.
      w_collide  = w_op_valid && (w_is_load || w_is_store) && !w_addr_err &&
                   host_req && (host_addr == w_op_alu[ADDR_W-1:0]);
      w_exec     = w_op_valid && !w_collide;
      w_nmt_we   = rst_n && w_exec && w_is_store && !w_addr_err;

      case (r_state)
         RUN:  if (w_collide) w_state_nxt = HOLD;
         HOLD: begin
            if (!w_collide)                              w_state_nxt = RUN;
            else if (r_retry_cnt == CNT_W'(MAX_RETRY))   w_state_nxt = SWITCH;
         end
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_retry_cnt <= '0;
         r_p_alu     <= '0;
         r_p_instr   <= '0;
         r_p_reg2    <= '0;
         r_p_store   <= 1'b0;
         r_alu       <= '0;
         r_ir        <= '0;
         r_lmd       <= '0;
         r_valid     <= 1'b0;
         r_addr_err  <= 1'b0;
         r_host_ack  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_host_ack <= host_req;
         r_valid    <= w_exec;
         r_addr_err <= w_exec && w_addr_err;

         if (w_state_nxt != HOLD)  r_retry_cnt <= '0;
         else if (r_state == RUN)  r_retry_cnt <= CNT_W'(1);
         else                      r_retry_cnt <= r_retry_cnt + CNT_W'(1);

         if (r_state == RUN && w_collide) begin
            r_p_alu   <= alu_i;
            r_p_instr <= instr_i;
            r_p_reg2  <= reg2_i;
            r_p_store <= w_is_store;
         end

         if (w_exec) begin
            r_alu <= w_op_alu;
            r_ir  <= w_op_instr;
            r_lmd <= (w_is_load && !w_addr_err) ? w_nmt_rdata : '0;
         end
      end
   end

   nmt_data_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_host_we    (host_req && host_rd_wr),
      .i_host_re    (host_req && !host_rd_wr),
      .i_host_addr  (host_addr),
      .i_host_wdata (host_wdata),
      .o_host_rdata (host_rdata),
      .i_nmt_we     (w_nmt_we),
      .i_nmt_addr   (w_op_alu[ADDR_W-1:0]),
      .i_nmt_wdata  (w_op_reg2),
      .o_nmt_rdata  (w_nmt_rdata)
   );

   assign stall_o          = rst_n && (w_collide || r_state == SWITCH);
   assign context_switch_o = rst_n && (r_state == SWITCH);
   assign alu_o            = r_alu;
   assign ir_o             = r_ir;
   assign lmd_o            = r_lmd;
   assign valid_o          = r_valid;
   assign addr_err_o       = r_addr_err;
   assign host_ack         = r_host_ack;

endmodule

// File: tb/tb_nmt_mem_stage.sv
// Randomized and directed bench for nmt_mem_stage against a behavioural
// memory/op model.
module tb_nmt_mem_stage;

   localparam int MAX_RETRY = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i;
   logic [31:0] alu_i, instr_i, reg2_i, cmd_type_i;
   logic        host_req, host_rd_wr;
   logic [8:0]  host_addr;
   logic [31:0] host_wdata;
   logic [31:0] host_rdata, alu_o, ir_o, lmd_o;
   logic        host_ack, valid_o, stall_o, context_switch_o, addr_err_o;

   nmt_mem_stage #(.MAX_RETRY(MAX_RETRY)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .valid_i          (valid_i),
      .alu_i            (alu_i),
      .instr_i          (instr_i),
      .reg2_i           (reg2_i),
      .cmd_type_i       (cmd_type_i),
      .host_req         (host_req),
      .host_rd_wr       (host_rd_wr),
      .host_addr        (host_addr),
      .host_wdata       (host_wdata),
      .host_rdata       (host_rdata),
      .host_ack         (host_ack),
      .alu_o            (alu_o),
      .ir_o             (ir_o),
      .lmd_o            (lmd_o),
      .valid_o          (valid_o),
      .stall_o          (stall_o),
      .context_switch_o (context_switch_o),
      .addr_err_o       (addr_err_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: memory image, blocked-op bookkeeping, expected outputs.
   logic [31:0] mem_m [512];
   bit          m_pend, m_switch;
   int          m_nblk;
   logic [31:0] p_alu, p_instr, p_reg2, p_cmd;
   logic [31:0] e_alu, e_ir, e_lmd, e_rdata;
   bit          e_valid, e_err, e_ack;
   int          cs_cnt, vld_cnt;
   bit          last_stall;

   function automatic bit m_blocked();
      logic [31:0] a, c;
      bit v;
      if (!rst_n || m_switch) return 1'b0;
      if (m_pend) begin v = 1'b1; a = p_alu; c = p_cmd; end
      else begin v = valid_i; a = alu_i; c = cmd_type_i; end
      return v && (c == 32'd1 || c == 32'd2) && (a[31:9] == 23'd0) &&
             host_req && (host_addr == a[8:0]);
   endfunction

   task automatic model_step();
      logic [31:0] a, c, ins, d;
      bit v, is_ld, is_st, err, blk;
      if (!rst_n) begin
         e_valid = 0; e_err = 0; e_ack = 0; e_rdata = 0;
         e_alu = 0; e_ir = 0; e_lmd = 0;
         m_pend = 0; m_switch = 0; m_nblk = 0;
         return;
      end
      e_ack = host_req;
      if (host_req && !host_rd_wr) e_rdata = mem_m[host_addr];
      e_valid = 0;
      e_err   = 0;
      if (m_switch) begin
         m_switch = 0; m_pend = 0; m_nblk = 0;
      end else begin
         blk = m_blocked();
         if (m_pend) begin v = 1; a = p_alu; c = p_cmd; ins = p_instr; d = p_reg2; end
         else begin v = valid_i; a = alu_i; c = cmd_type_i; ins = instr_i; d = reg2_i; end
         is_ld = (c == 32'd1);
         is_st = (c == 32'd2);
         err   = (is_ld || is_st) && (a[31:9] != 23'd0);
         if (v && blk) begin
            if (!m_pend) begin
               m_pend = 1; p_alu = a; p_cmd = c; p_instr = ins; p_reg2 = d; m_nblk = 0;
            end
            m_nblk++;
            if (m_nblk == MAX_RETRY + 1) begin m_switch = 1; m_pend = 0; end
         end else if (v) begin
            e_valid = 1; e_alu = a; e_ir = ins; e_err = err;
            e_lmd = (is_ld && !err) ? mem_m[a[8:0]] : 32'd0;
            if (is_st && !err) mem_m[a[8:0]] = d;
            m_pend = 0; m_nblk = 0;
         end
      end
      if (host_req && host_rd_wr) mem_m[host_addr] = host_wdata;
   endtask

   // Called at a negedge with inputs already driven.
   task automatic tick();
      #1;
      chk_eq("stall", stall_o, m_blocked() || (rst_n && m_switch));
      chk_eq("ctx_sw", context_switch_o, rst_n && m_switch);
      last_stall = stall_o;
      cs_cnt += context_switch_o;
      @(posedge clk);
      model_step();
      #1;
      chk_eq("valid", valid_o, e_valid);
      chk_eq("addr_err", addr_err_o, e_err);
      chk_eq("host_ack", host_ack, e_ack);
      chk_eq("host_rdata", host_rdata, e_rdata);
      if (e_valid || !rst_n) begin
         chk_eq("alu", alu_o, e_alu);
         chk_eq("ir", ir_o, e_ir);
         chk_eq("lmd", lmd_o, e_lmd);
      end
      vld_cnt += valid_o;
      @(negedge clk);
   endtask

   task automatic set_idle();
      valid_i = 0; alu_i = 0; instr_i = 0; reg2_i = 0; cmd_type_i = 0;
      host_req = 0; host_rd_wr = 0; host_addr = 0; host_wdata = 0;
   endtask

   task automatic set_op(input logic [31:0] cmd, input logic [31:0] a, input logic [31:0] d);
      valid_i = 1; cmd_type_i = cmd; alu_i = a; reg2_i = d; instr_i = $urandom;
   endtask

   task automatic set_host(input bit wr, input logic [8:0] a, input logic [31:0] d);
      host_req = 1; host_rd_wr = wr; host_addr = a; host_wdata = d;
   endtask

   task automatic no_op();
      valid_i = 0;
   endtask

   task automatic no_host();
      host_req = 0;
   endtask

   initial begin
      int r;
      set_idle();
      rst_n = 0;
      m_pend = 0; m_switch = 0; m_nblk = 0; cs_cnt = 0; vld_cnt = 0;
      tick();
      tick();
      chk_eq("rst_valid", valid_o, 0);
      chk_eq("rst_lmd", lmd_o, 0);
      rst_n = 1;

      set_op(32'd0, 32'h5, 32'h0);
      tick();
      chk_eq("alu_pass", alu_o, 32'h5);
      chk_eq("alu_lmd", lmd_o, 0);

      // Give every word a defined value.
      no_op();
      for (int a = 0; a < 512; a++) begin
         set_host(1, 9'(a), $urandom);
         tick();
      end
      no_host();

      // STORE then LOAD, then host read.
      set_op(32'd2, 32'h010, 32'hDEADBEEF); tick();
      set_op(32'd1, 32'h010, 32'h0);        tick();
      chk_eq("st_ld_lmd", lmd_o, 32'hDEADBEEF);
      no_op(); set_host(0, 9'h010, 0); tick();
      chk_eq("st_host_rd", host_rdata, 32'hDEADBEEF);
      chk_eq("st_host_ack", host_ack, 1);
      no_host();

      // Short collision: two blocked cycles then the load completes.
      set_op(32'd1, 32'h020, 0);
      set_host(1, 9'h020, 32'h1234); tick();
      chk_eq("sc_stall0", last_stall, 1);
      tick();
      chk_eq("sc_stall1", last_stall, 1);
      chk_eq("sc_novalid", valid_o, 0);
      no_host(); tick();
      chk_eq("sc_stall2", last_stall, 0);
      chk_eq("sc_lmd", lmd_o, 32'h1234);
      no_op(); tick();

      // Retry exhaustion.
      cs_cnt = 0; vld_cnt = 0;
      set_op(32'd2, 32'h030, 32'hAAAA0000);
      set_host(1, 9'h030, 32'h5555);
      for (int i = 0; i < 6; i++) tick();
      no_op(); no_host(); tick(); tick();
      chk_eq("rx_cs_pulses", cs_cnt, 1);
      chk_eq("rx_no_valid", vld_cnt, 0);
      set_host(0, 9'h030, 0); tick();
      chk_eq("rx_mem", host_rdata, 32'h5555);
      no_host();

      // Parallel host write and NMT store.
      set_host(1, 9'h001, 32'h11111111);
      set_op(32'd2, 32'h002, 32'h22222222); tick();
      chk_eq("par_stall", last_stall, 0);
      chk_eq("par_ack", host_ack, 1);
      chk_eq("par_valid", valid_o, 1);
      no_op(); set_host(0, 9'h001, 0); tick();
      chk_eq("par_w1", host_rdata, 32'h11111111);
      set_host(0, 9'h002, 0); tick();
      chk_eq("par_w2", host_rdata, 32'h22222222);
      no_host();

      // Address error.
      set_op(32'd1, 32'h200, 0); tick();
      chk_eq("ae_pulse", addr_err_o, 1);
      chk_eq("ae_lmd", lmd_o, 0);
      chk_eq("ae_valid", valid_o, 1);
      no_op(); tick();
      chk_eq("ae_clear", addr_err_o, 0);

      // Reset while holding a store.
      set_host(1, 9'h040, 32'h77); tick();
      set_op(32'd2, 32'h040, 32'h99);
      set_host(0, 9'h040, 0); tick(); tick();
      set_idle(); rst_n = 0; tick();
      chk_eq("rh_stall", stall_o, 0);
      rst_n = 1; tick();
      set_host(0, 9'h040, 0); tick();
      chk_eq("rh_mem", host_rdata, 32'h77);
      no_host(); tick();

      // Randomized traffic with sticky host addresses to provoke long holds.
      for (int i = 0; i < 3000; i++) begin
         valid_i = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 9);
         if (r < 3)      cmd_type_i = 32'd0;
         else if (r < 6) cmd_type_i = 32'd1;
         else if (r < 9) cmd_type_i = 32'd2;
         else begin
            case ($urandom_range(0, 2))
               0:       cmd_type_i = 32'd3;
               1:       cmd_type_i = 32'h00010001;
               default: cmd_type_i = 32'h00010002;
            endcase
         end
         alu_i   = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h200) : 32'($urandom_range(0, 7));
         instr_i = $urandom;
         reg2_i  = $urandom;
         host_req = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) host_addr = 9'($urandom_range(0, 7));
         host_rd_wr = $urandom_range(0, 1);
         host_wdata = $urandom;
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 0; host_req = 0;
         end else begin
            rst_n = 1;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/nmt_mem_stage.md
Name: nmt_mem_stage

Overview:
- MEM stage of the NMT pipeline; sits between the EXMEM register/mux pair and the MEMWB register/MPR.
- Performs NMT loads and stores on a 512-word local data memory.
- Serves host reads and writes on the same memory with host priority.
- Detects host/NMT address collisions, holds the NMT op for bounded retry, then raises a context-switch request so the MPRs save the thread.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 9, memory word-address width (matches host address bus)
- DEPTH, 512, memory words (2**ADDR_W)
- MAX_RETRY, 4, HOLD cycles tolerated before a context switch is requested

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- valid_i  in  1  EXMEM mux output carries a live op
- alu_i  in  DATA_W  ALU result; memory address for LOAD/STORE
- instr_i  in  DATA_W  instruction word
- reg2_i  in  DATA_W  store data
- cmd_type_i  in  DATA_W  op class: 0 ALU, 1 LOAD, 2 STORE; other values treated as ALU
- host_req  in  1  host access strobe
- host_rd_wr  in  1  1 = host write, 0 = host read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_rdata  out  DATA_W  host read data
- host_ack  out  1  host access completed
- alu_o  out  DATA_W  registered ALU result to MEMWB
- ir_o  out  DATA_W  registered instruction to MEMWB
- lmd_o  out  DATA_W  load memory data to MEMWB
- valid_o  out  1  outputs carry a completed op
- stall_o  out  1  hold upstream (EXMEM must not advance)
- context_switch_o  out  1  one-cycle context-switch request, ORed into the collision network
- addr_err_o  out  1  one-cycle pulse: NMT address out of range

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0; state RUN; retry_cnt 0; pending op cleared. Memory contents are not reset. A reset during HOLD drops the pending op; no write occurs.
- Memory: dual-access array, one host port and one NMT port. Both ports may act in the same cycle when addresses differ.
- Host path (all states):
  - host_req=1 is always served that cycle.
  - Write: mem[host_addr] <= host_wdata.
  - Read: host_rdata <= mem[host_addr] (old data).
  - host_ack=1 in the following cycle, otherwise 0.
  - host_rdata holds its last value.
- Collision: NMT mem op (LOAD/STORE) with host_req=1 and host_addr == op_addr[ADDR_W-1:0]. Host read or write both count.
- Address check: alu_i[DATA_W-1:ADDR_W] != 0 for a LOAD/STORE means out of range.
  - addr_err_o pulses next cycle.
  - Op completes with no memory access; lmd_o = 0; valid_o = 1.
- Latency: 1 cycle. Op accepted at edge N gives alu_o/ir_o/lmd_o/valid_o at edge N+1.
- ALU ops: pass through; lmd_o = 0; never collide.
- State RUN:
  - valid_i=0: valid_o=0 next.
  - Non-colliding op:
    - LOAD: lmd_o <= mem[addr].
    - STORE: mem[addr] <= reg2_i; lmd_o <= 0.
    - valid_o <= 1.
  - Colliding op:
    - Capture the op into pending regs.
    - valid_o <= 0; stall_o = 1 (combinational, same cycle); retry_cnt <= 1.
    - Go to HOLD.
- State HOLD:
  - stall_o = 1; upstream inputs are ignored.
  - Each cycle, re-evaluate collision on the pending address.
  - No collision: execute the pending op as in RUN; valid_o <= 1; go to RUN; stall_o drops in that cycle.
  - Collision with retry_cnt == MAX_RETRY: go to SWITCH.
  - Collision otherwise: retry_cnt++.
- State SWITCH (one cycle):
  - context_switch_o = 1; stall_o = 1.
  - Pending op discarded without memory access; the thread context is preserved by the MPRs.
  - valid_o = 0; retry_cnt <= 0; go to RUN.
- Host write and NMT store to the same address in the same cycle: host wins; NMT store deferred through HOLD.
- Host and NMT to different addresses in the same cycle: both complete.
- cmd_type_i is compared on its full width; 0x00000001 is LOAD, 0x00010001 is treated as ALU.

Decomposition:
- Shared package nmt_pkg:
  - CMD_ALU / CMD_LOAD / CMD_STORE constants
  - mem_state_t enum {RUN, HOLD, SWITCH}
  - DATA_W/ADDR_W defaults
- Sub-module nmt_data_ram: DEPTH x DATA_W, one registered-read host port plus one NMT port, write-first never; read returns old data.
- FSM, collision compare and pipeline output registers live in the top.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all outputs 0; after release, ALU op alu_i=0x5 -> next cycle alu_o=0x5, lmd_o=0, valid_o=1.
- STORE then LOAD: STORE addr 0x010 data 0xDEADBEEF, next cycle LOAD 0x010 -> lmd_o=0xDEADBEEF one cycle after the LOAD; host read 0x010 -> host_rdata=0xDEADBEEF, host_ack=1.
- Short collision: LOAD 0x020 while host writes 0x020=0x1234 for 2 cycles -> stall_o=1 for 2 cycles, no valid; third cycle load completes, lmd_o=0x1234.
- Retry exhaustion: STORE 0x030 with host_req on 0x030 held for 6 cycles -> after MAX_RETRY HOLD cycles a single context_switch_o pulse; mem[0x030] keeps the host value; valid_o never 1 for that op.
- Parallel access: host write 0x001 and NMT STORE 0x002 in the same cycle -> no stall, both words written, host_ack=1, valid_o=1.
- Address error and reset mid-HOLD: LOAD with alu_i=0x00000200 -> addr_err_o pulse, lmd_o=0, valid_o=1; then force HOLD and assert rst_n=0 -> pending STORE never written, stall_o=0.
